// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a common-anode 3-digit 7-segment display.
// Double-buffered BCD digits, leading-zero blanking and anode dead time between digit slots.
module seg7_scan_driver #(
   parameter int DIV  = 50000,
   parameter int DEAD = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] BCD_0,
   input  logic [3:0] BCD_1,
   input  logic [3:0] BCD_2,
   input  logic       load,
   input  logic       blank_lz,
   output logic [6:0] seg,
   output logic [2:0] an,
   output logic       frame_done
);

   localparam int NUM_DIG = 3;
   localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST_C = CW'(DIV - 1);
   localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
   localparam logic [6:0]    SEG_OFF = 7'b1111111;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      s = 7'b0111111;
      case (d)
         4'd0: s = 7'b1000000;
         4'd1: s = 7'b1111001;
         4'd2: s = 7'b0100100;
         4'd3: s = 7'b0110000;
         4'd4: s = 7'b0011001;
         4'd5: s = 7'b0010010;
         4'd6: s = 7'b0000010;
         4'd7: s = 7'b1111000;
         4'd8: s = 7'b0000000;
         4'd9: s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   logic [CW-1:0]                 r_cnt;
   logic [1:0]                    r_idx;
   logic [NUM_DIG-1:0][3:0]       r_shadow;
   logic [NUM_DIG-1:0][3:0]       r_active;
   logic                          r_pending;

   logic [NUM_DIG-1:0][3:0]       w_bcd;
   logic                          w_wrap;
   logic                          w_frame;
   logic                          w_dead;
   logic [NUM_DIG-1:0]            w_blank;
   logic [NUM_DIG-1:0][6:0]       w_dseg;
   logic [6:0]                    w_seg_sel;

   assign w_bcd   = {BCD_2, BCD_1, BCD_0};
   assign w_wrap  = (r_cnt == LAST_C);
   assign w_frame = w_wrap && (r_idx == 2'd2);

   // Blanking is a chain from the top digit down; a dash (10..15) never counts as zero.
   assign w_blank[2] = blank_lz && (r_active[2] == 4'd0);
   assign w_blank[1] = w_blank[2] && (r_active[1] == 4'd0);
   assign w_blank[0] = 1'b0;

   for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
      assign w_dseg[g] = w_blank[g] ? SEG_OFF : decode(r_active[g]);
   end

   if (DEAD == 0) begin : g_nodead
      assign w_dead = 1'b0;
   end else begin : g_dead
      assign w_dead = (r_cnt < DEAD_C);
   end

   always_comb begin
      w_seg_sel = SEG_OFF;
      case (r_idx)
         2'd0:    w_seg_sel = w_dseg[0];
         2'd1:    w_seg_sel = w_dseg[1];
         2'd2:    w_seg_sel = w_dseg[2];
         default: w_seg_sel = SEG_OFF;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_idx <= 2'd0;
      end else if (w_wrap) begin
         r_cnt <= '0;
         r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // A load on the boundary cycle bypasses the shadow so it is not delayed a whole frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow  <= '0;
         r_active  <= '0;
         r_pending <= 1'b0;
      end else begin
         if (load) r_shadow <= w_bcd;
         if (w_frame) begin
            if (r_pending || load) r_active <= load ? w_bcd : r_shadow;
            r_pending <= 1'b0;
         end else if (load) begin
            r_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg        <= SEG_OFF;
         an         <= 3'b111;
         frame_done <= 1'b0;
      end else begin
         frame_done <= w_frame;
         if (w_dead) begin
            seg <= SEG_OFF;
            an  <= 3'b111;
         end else begin
            seg <= w_seg_sel;
            an  <= ~(3'b001 << r_idx);
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIV=4, DEAD=1 (12-cycle frames).
module tb_seg7_scan_driver;

   localparam logic [6:0] S0 = 7'b1000000, S2 = 7'b0100100, S4 = 7'b0011001,
                          S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000,
                          S8 = 7'b0000000, S9 = 7'b0010000, SD = 7'b0111111,
                          SB = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] BCD_0 = '0, BCD_1 = '0, BCD_2 = '0;
   logic       load = 1'b0, blank_lz = 1'b0;
   logic [6:0] seg;
   logic [2:0] an;
   logic       frame_done;

   int         n_chk = 0, n_fail = 0, cyc = 0;
   logic [6:0] exp_seg [3];

   seg7_scan_driver #(.DIV(4), .DEAD(1)) dut (
      .clk(clk), .rst(rst), .BCD_0(BCD_0), .BCD_1(BCD_1), .BCD_2(BCD_2),
      .load(load), .blank_lz(blank_lz), .seg(seg), .an(an), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_exp(input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
      exp_seg[2] = s2; exp_seg[1] = s1; exp_seg[0] = s0;
   endtask

   // Output after edge k reflects the counter state before it: t = k-1 cycles since release.
   task automatic step();
      int t, c, i;
      logic [2:0] ea;
      logic [6:0] es;
      @(posedge clk); #1;
      cyc++;
      t = cyc - 1; c = t % 4; i = (t / 4) % 3;
      if (c == 0) begin
         ea = 3'b111; es = SB;
      end else begin
         ea = ~(3'b001 << i); es = exp_seg[i];
      end
      chk($sformatf("an@%0d", cyc), 32'(an), 32'(ea));
      chk($sformatf("seg@%0d", cyc), 32'(seg), 32'(es));
      chk($sformatf("frame_done@%0d", cyc), 32'(frame_done), 32'((cyc % 12) == 0));
   endtask

   task automatic run_to(input int m);
      do step(); while ((cyc % 12) != m);
   endtask

   task automatic load_step(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
      BCD_2 = d2; BCD_1 = d1; BCD_0 = d0; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_seg"}, 32'(seg), 32'(SB));
      chk({tag, "_an"}, 32'(an), 32'(3'b111));
      chk({tag, "_fd"}, 32'(frame_done), 32'(1'b0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 chk_reset("reset");
      rst = 1'b0; cyc = 0;

      // Power-up scan shows 000 with the dead-time pattern
      set_exp(S0, S0, S0);
      run_to(0);

      // Load 255 mid-frame: no change until the next boundary
      run_to(5);
      load_step(4'd2, 4'd5, 4'd5);
      run_to(0);
      set_exp(S2, S5, S5);
      run_to(0);

      // Async reset mid-scan, then restart from idx=0 showing 000
      run_to(6);
      rst = 1'b1;
      #2 chk_reset("async_rst");
      @(posedge clk); #1 chk_reset("rst_held");
      rst = 1'b0; cyc = 0;
      set_exp(S0, S0, S0);
      run_to(0);

      // Double buffering: 123 then 456 in one frame, only 456 shown
      run_to(2);
      load_step(4'd1, 4'd2, 4'd3);
      step();
      load_step(4'd4, 4'd5, 4'd6);
      run_to(0);
      set_exp(S4, S5, S6);
      run_to(0);

      // Load on the boundary cycle goes straight to the next frame
      run_to(11);
      load_step(4'd7, 4'd8, 4'd9);
      chk("pending_after_boundary", 32'(dut.r_pending), 32'(1'b0));
      set_exp(S7, S8, S9);
      run_to(0);

      // Leading-zero blanking
      blank_lz = 1'b1;
      run_to(3);
      load_step(4'd0, 4'd0, 4'd7);
      run_to(0);
      set_exp(SB, SB, S7);
      run_to(3);
      load_step(4'd0, 4'd5, 4'd0);
      run_to(0);
      set_exp(SB, S5, S0);
      run_to(3);
      load_step(4'd0, 4'd0, 4'd0);
      run_to(0);
      set_exp(SB, SB, S0);
      run_to(3);
      load_step(4'd0, 4'hC, 4'd0);
      run_to(0);
      set_exp(SB, SD, S0);
      run_to(0);

      // blank_lz is live: clearing it re-exposes the hundreds zero
      blank_lz = 1'b0;
      set_exp(S0, SD, S0);
      run_to(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
